// File: rtl/calc_input_sequencer.sv
// Input front end for the 3-bit calculator: synchronises and debounces the buttons, then walks the
// user through operand A, operator, operand B and result, driving the display stage from registers.
module calc_input_sequencer #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:2] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [0:3] btn_op,
  output logic [0:2] in_1,
  output logic [0:2] in_2,
  output logic [0:3] oper,
  output logic       result_valid,
  output logic [1:0] stage
);

  localparam int unsigned CNT_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned NumBtn = 6;
  // Flip on the edge where the counter would reach DEB_CYCLES.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    StA    = 2'b00,
    StOp   = 2'b01,
    StB    = 2'b10,
    StShow = 2'b11
  } state_e;

  // Bit map: [5] clear, [4] enter, [3:0] operator buttons add..div.
  logic [NumBtn-1:0] btn_raw;
  assign btn_raw = {btn_clear, btn_enter, btn_op[0], btn_op[1], btn_op[2], btn_op[3]};

  logic [NumBtn-1:0] btn_s1_q, btn_s2_q;
  logic [NumBtn-1:0] deb_q, deb_d;
  logic [NumBtn-1:0] press_q, press_d;
  logic [CNT_W-1:0]  cnt_q [NumBtn];
  logic [CNT_W-1:0]  cnt_d [NumBtn];
  logic [0:2]        sw_s1_q, sw_s2_q;

  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          deb_d[i]   = btn_s2_q[i];
          press_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      deb_q    <= '0;
      press_q  <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      deb_q    <= deb_d;
      press_q  <= press_d;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic       clear_ev, enter_ev, op_valid;
  logic [0:3] op_ev;
  assign clear_ev = press_q[5];
  assign enter_ev = press_q[4];
  assign op_ev    = press_q[3:0];
  // Simultaneous operator presses are ambiguous and dropped; enter outranks any operator.
  assign op_valid = $onehot(op_ev) && !enter_ev;

  state_e     state_q;
  logic [0:2] in_1_q, in_2_q;
  logic [0:3] oper_q;
  logic       result_valid_q;

  always_ff @(posedge clk) begin
    if (rst || clear_ev) begin
      state_q        <= StA;
      in_1_q         <= '0;
      in_2_q         <= '0;
      oper_q         <= '0;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StA: begin
          in_1_q <= sw_s2_q;
          oper_q <= '0;
          if (enter_ev) state_q <= StOp;
        end
        StOp: begin
          if (op_valid) begin
            oper_q  <= op_ev;
            state_q <= StB;
          end
        end
        StB: begin
          in_2_q <= sw_s2_q;
          if (enter_ev) begin
            state_q        <= StShow;
            result_valid_q <= 1'b1;
          end else if (op_valid) begin
            oper_q <= op_ev;
          end
        end
        StShow: begin
          if (enter_ev) begin
            state_q        <= StA;
            oper_q         <= '0;
            result_valid_q <= 1'b0;
          end
        end
        default: state_q <= StA;
      endcase
    end
  end

  assign in_1         = in_1_q;
  assign in_2         = in_2_q;
  assign oper         = oper_q;
  assign result_valid = result_valid_q;
  assign stage        = state_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer with DEB_CYCLES=4: table-driven button presses checked through a
// scoreboard queue, plus hand-written bounce, clear/enter collision and mid-sequence reset cases.
module tb_calc_input_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:2] sw;
  logic       btn_enter, btn_clear;
  logic [0:3] btn_op;
  logic [0:2] in_1, in_2;
  logic [0:3] oper;
  logic       result_valid;
  logic [1:0] stage;

  always #5 clk = ~clk;

  calc_input_sequencer #(.DEB_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .btn_op      (btn_op),
    .in_1        (in_1),
    .in_2        (in_2),
    .oper        (oper),
    .result_valid(result_valid),
    .stage       (stage)
  );

  typedef struct packed {
    logic [2:0] in_1;
    logic [2:0] in_2;
    logic [3:0] oper;
    logic [1:0] stage;
    logic       rv;
  } exp_t;

  typedef struct {
    string      name;
    logic [2:0] sw;
    logic       enter;
    logic       clear;
    logic [3:0] op;
    exp_t       exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[17];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_front(input string name);
    exp_t got, e;
    got = {in_1, in_2, oper, stage, result_valid};
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got %b", name, got);
      return;
    end
    e = sb_q.pop_front();
    if (got === e) n_pass++;
    else $display("FAIL %s: got in_1=%b in_2=%b oper=%b stage=%b rv=%b, want in_1=%b in_2=%b oper=%b stage=%b rv=%b",
                  name, got.in_1, got.in_2, got.oper, got.stage, got.rv,
                  e.in_1, e.in_2, e.oper, e.stage, e.rv);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Hold the buttons long enough to be accepted, then release long enough to settle.
  task automatic press(input logic [2:0] s, input logic en, input logic cl, input logic [3:0] op);
    sw        = s;
    btn_enter = en;
    btn_clear = cl;
    btn_op    = op;
    repeat (10) tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    btn_op    = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic run_row(input int i);
    sb_q.push_back(vecs[i].exp);
    press(vecs[i].sw, vecs[i].enter, vecs[i].clear, vecs[i].op);
    check_front(vecs[i].name);
  endtask

  initial begin
    int   changes;
    logic [1:0] prev;

    //           name            sw      en    cl    op         in_1    in_2    oper     st     rv
    vecs[0]  = '{"a_enter",      3'b011, 1'b1, 1'b0, 4'b0000, '{3'b011, 3'b000, 4'b0000, 2'b01, 1'b0}};
    vecs[1]  = '{"op_add",       3'b000, 1'b0, 1'b0, 4'b1000, '{3'b011, 3'b000, 4'b1000, 2'b10, 1'b0}};
    vecs[2]  = '{"b_enter",      3'b100, 1'b1, 1'b0, 4'b0000, '{3'b011, 3'b100, 4'b1000, 2'b11, 1'b1}};
    vecs[3]  = '{"show_op_ign",  3'b111, 1'b0, 1'b0, 4'b0100, '{3'b011, 3'b100, 4'b1000, 2'b11, 1'b1}};
    vecs[4]  = '{"show_enter",   3'b010, 1'b1, 1'b0, 4'b0000, '{3'b010, 3'b100, 4'b0000, 2'b00, 1'b0}};
    vecs[5]  = '{"op_enter_ign", 3'b010, 1'b1, 1'b0, 4'b0000, '{3'b010, 3'b100, 4'b0000, 2'b01, 1'b0}};
    vecs[6]  = '{"op_two_ign",   3'b000, 1'b0, 1'b0, 4'b0110, '{3'b010, 3'b100, 4'b0000, 2'b01, 1'b0}};
    vecs[7]  = '{"op_div",       3'b000, 1'b0, 1'b0, 4'b0001, '{3'b010, 3'b000, 4'b0001, 2'b10, 1'b0}};
    vecs[8]  = '{"b_zero_enter", 3'b000, 1'b1, 1'b0, 4'b0000, '{3'b010, 3'b000, 4'b0001, 2'b11, 1'b1}};
    vecs[9]  = '{"show_back",    3'b101, 1'b1, 1'b0, 4'b0000, '{3'b101, 3'b000, 4'b0000, 2'b00, 1'b0}};
    vecs[10] = '{"a_enter2",     3'b101, 1'b1, 1'b0, 4'b0000, '{3'b101, 3'b000, 4'b0000, 2'b01, 1'b0}};
    vecs[11] = '{"op_mul",       3'b110, 1'b0, 1'b0, 4'b0010, '{3'b101, 3'b110, 4'b0010, 2'b10, 1'b0}};
    vecs[12] = '{"b_reselect",   3'b110, 1'b0, 1'b0, 4'b1000, '{3'b101, 3'b110, 4'b1000, 2'b10, 1'b0}};
    vecs[13] = '{"b_two_ign",    3'b001, 1'b0, 1'b0, 4'b1100, '{3'b101, 3'b001, 4'b1000, 2'b10, 1'b0}};
    vecs[14] = '{"clr_enter",    3'b000, 1'b1, 1'b1, 4'b0000, '{3'b000, 3'b000, 4'b0000, 2'b00, 1'b0}};
    vecs[15] = '{"a_enter3",     3'b011, 1'b1, 1'b0, 4'b0000, '{3'b011, 3'b000, 4'b0000, 2'b01, 1'b0}};
    vecs[16] = '{"op_sub",       3'b111, 1'b0, 1'b0, 4'b0100, '{3'b011, 3'b111, 4'b0100, 2'b10, 1'b0}};

    rst       = 1'b1;
    sw        = 3'b000;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    btn_op    = 4'b0000;
    repeat (3) tick();
    rst = 1'b0;
    sb_q.push_back('{3'b000, 3'b000, 4'b0000, 2'b00, 1'b0});
    repeat (20) tick();
    check_front("reset_idle");

    for (int i = 0; i <= 4; i++) run_row(i);

    // Bouncing enter must not register; the steady hold lands on exactly the 7th edge.
    changes = 0;
    prev    = stage;
    for (int i = 0; i < 12; i++) begin
      btn_enter = ((i / 2) % 2) == 0;
      tick();
      if (stage != prev) changes++;
      prev = stage;
    end
    btn_enter = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (stage != prev) changes++;
      prev = stage;
    end
    sb_q.push_back('{3'b010, 3'b100, 4'b0000, 2'b00, 1'b0});
    check_front("bounce_before_7");
    tick();
    if (stage != prev) changes++;
    prev = stage;
    sb_q.push_back('{3'b010, 3'b100, 4'b0000, 2'b01, 1'b0});
    check_front("bounce_at_7");
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stage != prev) changes++;
      prev = stage;
    end
    btn_enter = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stage != prev) changes++;
      prev = stage;
    end
    check_int("bounce_transitions", changes, 1);

    for (int i = 5; i <= 16; i++) run_row(i);

    // Reset in the middle of operand B entry discards everything on the next edge.
    sw  = 3'b101;
    rst = 1'b1;
    sb_q.push_back('{3'b000, 3'b000, 4'b0000, 2'b00, 1'b0});
    tick();
    check_front("rst_mid_b");
    rst = 1'b0;
    sw  = 3'b000;
    sb_q.push_back('{3'b000, 3'b000, 4'b0000, 2'b00, 1'b0});
    repeat (10) tick();
    check_front("after_rst_idle");

    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
